// File: rtl/fifo_read_serializer.sv
// Pops words from a show-ahead FIFO read port and streams each one as
// Beats narrower beats, least-significant first, on a valid/ready/last stream.
module fifo_read_serializer #(
  parameter int unsigned DataWidth = 64,
  parameter int unsigned BeatWidth = 32
) (
  input  logic                 Clk,
  input  logic                 Rst,
  input  logic [DataWidth-1:0] FifoRData,
  input  logic                 FifoREmpty,
  output logic                 FifoRInc,
  output logic [BeatWidth-1:0] OutData,
  output logic                 OutValid,
  output logic                 OutLast,
  input  logic                 OutReady,
  input  logic                 Flush,
  output logic                 Busy
);

  localparam int unsigned Beats = DataWidth / BeatWidth;
  localparam int unsigned CntW  = (Beats > 1) ? $clog2(Beats) : 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(Beats - 1);

  typedef enum logic {
    IDLE,
    SEND
  } state_t;

  state_t                 state;
  logic [DataWidth-1:0]   word;
  logic [CntW-1:0]        cnt;

  logic                   send;
  logic                   valid;
  logic                   last;
  logic                   xfer;
  logic                   pop;
  logic [BeatWidth-1:0]   beat;

  assign send  = (state == SEND);
  assign valid = send & ~Flush;
  assign last  = (cnt == LastCnt);
  assign xfer  = valid & OutReady;
  // Pop when idle, or on acceptance of the final beat so words run back-to-back.
  // Rst gates the strobe because the FIFO may be non-empty while we are held in reset.
  assign pop   = Rst & ~Flush & ~FifoREmpty & (~send | (xfer & last));

  always_comb begin
    beat = '0;
    for (int unsigned i = 0; i < Beats; i++) begin
      if (cnt == CntW'(i)) beat = word[i*BeatWidth +: BeatWidth];
    end
  end

  assign OutValid = valid;
  assign OutData  = valid ? beat : '0;
  assign OutLast  = valid & last;
  assign FifoRInc = pop;
  assign Busy     = send;

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state <= IDLE;
      word  <= '0;
      cnt   <= '0;
    end else if (Flush) begin
      state <= IDLE;
      cnt   <= '0;
    end else if (pop) begin
      state <= SEND;
      word  <= FifoRData;
      cnt   <= '0;
    end else if (xfer) begin
      if (last) begin
        state <= IDLE;
        cnt   <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_fifo_read_serializer.sv
// Randomized bench for fifo_read_serializer: a queue-based FIFO and a word/beat-index
// model predict every output each cycle; directed phases pin literal values.
module tb_fifo_read_serializer;

  localparam int unsigned DW    = 64;
  localparam int unsigned BW    = 32;
  localparam int unsigned BEATS = DW / BW;

  logic          Clk = 1'b0;
  logic          Rst = 1'b0;
  logic [DW-1:0] FifoRData = '0;
  logic          FifoREmpty = 1'b1;
  logic          FifoRInc;
  logic [BW-1:0] OutData;
  logic          OutValid;
  logic          OutLast;
  logic          OutReady = 1'b0;
  logic          Flush = 1'b0;
  logic          Busy;

  fifo_read_serializer #(.DataWidth(DW), .BeatWidth(BW)) dut (
    .Clk(Clk), .Rst(Rst), .FifoRData(FifoRData), .FifoREmpty(FifoREmpty),
    .FifoRInc(FifoRInc), .OutData(OutData), .OutValid(OutValid), .OutLast(OutLast),
    .OutReady(OutReady), .Flush(Flush), .Busy(Busy)
  );

  always #5 Clk = ~Clk;

  logic [DW-1:0] fq[$];
  bit            m_act = 1'b0;
  logic [DW-1:0] m_word = '0;
  int unsigned   m_idx = 0;

  int checks = 0;
  int errors = 0;

  logic [BW-1:0] s_data;
  logic          s_valid, s_last, s_pop, s_busy;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Whole outputs are predicted from the held word, the beat index and this cycle's inputs.
  task automatic step(input bit rdy, input bit fl);
    bit            e_valid, e_last, e_pop, acc;
    logic [BW-1:0] e_data;
    @(negedge Clk);
    OutReady   = rdy;
    Flush      = fl;
    FifoREmpty = (fq.size() == 0);
    FifoRData  = (fq.size() != 0) ? fq[0] : {$urandom(), $urandom()};
    #1;
    e_valid = m_act && !fl;
    e_last  = e_valid && (m_idx == BEATS - 1);
    e_data  = e_valid ? BW'(m_word >> (m_idx * BW)) : '0;
    acc     = e_valid && rdy;
    e_pop   = !fl && (fq.size() != 0) && (!m_act || (acc && m_idx == BEATS - 1));
    s_data = OutData; s_valid = OutValid; s_last = OutLast; s_pop = FifoRInc; s_busy = Busy;
    chk("m_valid", 64'(OutValid), 64'(e_valid));
    chk("m_data",  64'(OutData),  64'(e_data));
    chk("m_last",  64'(OutLast),  64'(e_last));
    chk("m_pop",   64'(FifoRInc), 64'(e_pop));
    chk("m_busy",  64'(Busy),     64'(m_act));
    @(posedge Clk);
    if (fl) begin
      m_act = 1'b0; m_idx = 0;
    end else if (e_pop) begin
      m_word = fq.pop_front(); m_act = 1'b1; m_idx = 0;
    end else if (acc) begin
      if (m_idx == BEATS - 1) begin m_act = 1'b0; m_idx = 0; end
      else m_idx++;
    end
  endtask

  logic [DW-1:0] w, w2;
  int pops, valids, guard;

  initial begin
    // reset state
    #3;
    chk("rst_valid", 64'(OutValid), 64'd0);
    chk("rst_data",  64'(OutData),  64'd0);
    chk("rst_last",  64'(OutLast),  64'd0);
    chk("rst_pop",   64'(FifoRInc), 64'd0);
    chk("rst_busy",  64'(Busy),     64'd0);
    @(negedge Clk); @(negedge Clk);
    Rst = 1'b1;

    // empty FIFO after reset
    for (int i = 0; i < 10; i++) begin
      step(1'b1, 1'b0);
      chk("empty_pop",   64'(s_pop),   64'd0);
      chk("empty_valid", 64'(s_valid), 64'd0);
      chk("empty_data",  64'(s_data),  64'd0);
    end

    // single word
    fq.push_back(64'h1122334455667788);
    step(1'b1, 1'b0);
    chk("single_pop", 64'(s_pop), 64'd1);
    chk("single_v0",  64'(s_valid), 64'd0);
    step(1'b1, 1'b0);
    chk("single_b0",  64'(s_data), 64'h55667788);
    chk("single_l0",  64'(s_last), 64'd0);
    chk("single_p1",  64'(s_pop),  64'd0);
    step(1'b1, 1'b0);
    chk("single_b1",  64'(s_data), 64'h11223344);
    chk("single_l1",  64'(s_last), 64'd1);
    step(1'b1, 1'b0);
    chk("single_end_v", 64'(s_valid), 64'd0);
    chk("single_end_b", 64'(s_busy),  64'd0);

    // back-to-back A, B, C
    for (int i = 0; i < 3; i++) fq.push_back({$urandom(), $urandom()});
    pops = 0; valids = 0;
    for (int i = 0; i < 7; i++) begin
      step(1'b1, 1'b0);
      chk("b2b_pop",   64'(s_pop),   64'((i == 0 || i == 2 || i == 4) ? 1 : 0));
      chk("b2b_valid", 64'(s_valid), 64'((i >= 1) ? 1 : 0));
      pops += int'(s_pop); valids += int'(s_valid);
    end
    chk("b2b_pops",   64'(pops),   64'd3);
    chk("b2b_valids", 64'(valids), 64'd6);
    step(1'b1, 1'b0);
    chk("b2b_idle", 64'(s_valid), 64'd0);

    // backpressure on the final beat with the next word waiting
    w = {$urandom(), $urandom()}; w2 = {$urandom(), $urandom()};
    fq.push_back(w); fq.push_back(w2);
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    chk("bp_b0", 64'(s_data), 64'(w[31:0]));
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 1'b0);
      chk("bp_hold_data", 64'(s_data),  64'(w[63:32]));
      chk("bp_hold_last", 64'(s_last),  64'd1);
      chk("bp_hold_v",    64'(s_valid), 64'd1);
      chk("bp_hold_pop",  64'(s_pop),   64'd0);
    end
    step(1'b1, 1'b0);
    chk("bp_resume_pop", 64'(s_pop), 64'd1);
    step(1'b1, 1'b0);
    chk("bp_next_b0", 64'(s_data), 64'(w2[31:0]));
    step(1'b1, 1'b0);
    chk("bp_next_b1", 64'(s_data), 64'(w2[63:32]));
    step(1'b1, 1'b0);

    // flush after beat 0
    w2 = {$urandom(), $urandom()};
    fq.push_back(64'hAAAA_BBBB_CCCC_DDDD); fq.push_back(w2);
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    chk("fl_b0", 64'(s_data), 64'hCCCCDDDD);
    step(1'b1, 1'b1);
    chk("fl_valid", 64'(s_valid), 64'd0);
    chk("fl_pop",   64'(s_pop),   64'd0);
    step(1'b1, 1'b0);
    chk("fl_repop", 64'(s_pop),  64'd1);
    chk("fl_busy",  64'(s_busy), 64'd0);
    step(1'b1, 1'b0);
    chk("fl_next_b0", 64'(s_data), 64'(w2[31:0]));
    chk("fl_next_l0", 64'(s_last), 64'd0);
    step(1'b1, 1'b0);
    chk("fl_next_b1", 64'(s_data), 64'(w2[63:32]));
    step(1'b1, 1'b0);

    // reset mid-word with Cnt=1 and OutReady=0
    w = {$urandom(), $urandom()};
    fq.push_back(w); fq.push_back({$urandom(), $urandom()});
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    @(negedge Clk);
    OutReady = 1'b0; FifoREmpty = 1'b0; FifoRData = fq[0];
    #1;
    chk("rmw_pre_data", 64'(OutData), 64'(w[63:32]));
    #1;
    Rst = 1'b0;
    #1;
    chk("rmw_valid", 64'(OutValid), 64'd0);
    chk("rmw_data",  64'(OutData),  64'd0);
    chk("rmw_last",  64'(OutLast),  64'd0);
    chk("rmw_pop",   64'(FifoRInc), 64'd0);
    chk("rmw_busy",  64'(Busy),     64'd0);
    @(posedge Clk); #1;
    chk("rmw_pop_hold", 64'(FifoRInc), 64'd0);
    fq.delete();
    m_act = 1'b0; m_idx = 0;
    @(negedge Clk);
    FifoREmpty = 1'b1;
    Rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b0);
      chk("rmw_quiet", 64'(s_valid), 64'd0);
    end

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 2) == 0 && fq.size() < 8) fq.push_back({$urandom(), $urandom()});
      step($urandom_range(0, 9) < 7, $urandom_range(0, 19) == 0);
    end
    guard = 0;
    while ((fq.size() != 0 || m_act) && guard < 200) begin
      step(1'b1, 1'b0);
      guard++;
    end
    chk("drain_done", 64'(guard < 200), 64'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
